// File: rtl/pc_gen_mc.sv
// Program-counter generator for the fetch front end: prioritised redirects, valid/ready fetch
// handshake, epoch tagging of every fetch, and trapping of misaligned targets.
module pc_gen_mc #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NUM_REDIR   = 4,
   parameter int unsigned EPOCH_W     = 3,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      reset_ni,
   input  logic                      enable_i,
   input  logic [XLEN-1:0]           initial_pc_i,
   input  logic [NUM_REDIR-1:0]      redir_valid_i,
   input  logic [NUM_REDIR*XLEN-1:0] redir_target_i,
   output logic                      fetch_valid_o,
   input  logic                      fetch_ready_i,
   output logic [XLEN-1:0]           fetch_pc_o,
   output logic [EPOCH_W-1:0]        fetch_epoch_o,
   output logic                      redirect_taken_o,
   output logic [NUM_REDIR-1:0]      redirect_src_o,
   output logic                      misalign_o,
   output logic [XLEN-1:0]           fault_pc_o
);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   logic [1:0]           state_q, state_n;
   logic [XLEN-1:0]      pc_q, pc_n;
   logic [EPOCH_W-1:0]   epoch_q, epoch_n;
   logic [NUM_REDIR-1:0] pend_src_q, pend_src_n;
   logic [XLEN-1:0]      pend_tgt_q, pend_tgt_n;
   logic                 valid_q, valid_n;
   logic                 taken_q, taken_n;
   logic [NUM_REDIR-1:0] src_q, src_n;
   logic                 mis_q, mis_n;
   logic [XLEN-1:0]      fault_q, fault_n;

   logic [NUM_REDIR-1:0] masked_in;
   logic [NUM_REDIR-1:0] new_oh;
   logic [XLEN-1:0]      new_tgt;
   logic                 has_new;
   logic [NUM_REDIR-1:0] win_oh;
   logic [XLEN-1:0]      win_raw;
   logic [XLEN-1:0]      win_tgt;
   logic                 have_win;
   logic                 tgt_bad;
   logic                 boot_bad;
   logic [XLEN-1:0]      boot_pc;

   // Redirect arbitration: FAULT only listens to channel 0; fresh requests beat pending ones
   always_comb begin
      masked_in = (state_q == ST_FAULT) ? (redir_valid_i & NUM_REDIR'(1)) : redir_valid_i;
      new_oh    = '0;
      new_tgt   = '0;
      for (int k = NUM_REDIR - 1; k >= 0; k--) begin
         if (masked_in[k]) begin
            new_oh  = NUM_REDIR'(1) << k;
            new_tgt = redir_target_i[k*XLEN +: XLEN];
         end
      end
      has_new  = |masked_in;
      win_oh   = has_new ? new_oh : pend_src_q;
      win_raw  = has_new ? new_tgt : pend_tgt_q;
      have_win = |win_oh;
      win_tgt  = ALIGN_CHECK ? win_raw : {win_raw[XLEN-1:2], 2'b00};
      tgt_bad  = ALIGN_CHECK && (win_raw[1:0] != 2'b00);
      boot_bad = ALIGN_CHECK && (initial_pc_i[1:0] != 2'b00);
      boot_pc  = ALIGN_CHECK ? initial_pc_i : {initial_pc_i[XLEN-1:2], 2'b00};
   end

   // Next-state and registered-output logic
   always_comb begin
      state_n    = state_q;
      pc_n       = pc_q;
      epoch_n    = epoch_q;
      pend_src_n = pend_src_q;
      pend_tgt_n = pend_tgt_q;
      taken_n    = 1'b0;
      src_n      = '0;
      fault_n    = fault_q;

      if (!enable_i) begin
         if (has_new) begin
            pend_src_n = new_oh;
            pend_tgt_n = new_tgt;
         end
      end else begin
         pend_src_n = '0;
         pend_tgt_n = '0;
         if (have_win) begin
            // Redirect overrides any same-cycle handshake increment
            epoch_n = epoch_q + EPOCH_W'(1);
            taken_n = 1'b1;
            src_n   = win_oh;
            if (tgt_bad) begin
               state_n = ST_FAULT;
               fault_n = win_raw;
            end else begin
               state_n = ST_RUN;
               pc_n    = win_tgt;
            end
         end else begin
            case (state_q)
               ST_BOOT: begin
                  if (boot_bad) begin
                     state_n = ST_FAULT;
                     fault_n = initial_pc_i;
                  end else begin
                     state_n = ST_RUN;
                     pc_n    = boot_pc;
                  end
               end
               ST_RUN: begin
                  if (fetch_ready_i) begin
                     pc_n = pc_q + XLEN'(4);
                  end
               end
               ST_FAULT: ;
               default: state_n = ST_BOOT;
            endcase
         end
      end

      valid_n = (state_n == ST_RUN);
      mis_n   = (state_n == ST_FAULT);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= ST_BOOT;
         pc_q       <= '0;
         epoch_q    <= '0;
         pend_src_q <= '0;
         pend_tgt_q <= '0;
         valid_q    <= 1'b0;
         taken_q    <= 1'b0;
         src_q      <= '0;
         mis_q      <= 1'b0;
         fault_q    <= '0;
      end else begin
         state_q    <= state_n;
         pc_q       <= pc_n;
         epoch_q    <= epoch_n;
         pend_src_q <= pend_src_n;
         pend_tgt_q <= pend_tgt_n;
         valid_q    <= valid_n;
         taken_q    <= taken_n;
         src_q      <= src_n;
         mis_q      <= mis_n;
         fault_q    <= fault_n;
      end
   end

   assign fetch_valid_o    = valid_q;
   assign fetch_pc_o       = pc_q;
   assign fetch_epoch_o    = epoch_q;
   assign redirect_taken_o = taken_q;
   assign redirect_src_o   = src_q;
   assign misalign_o       = mis_q;
   assign fault_pc_o       = fault_q;

endmodule
